// File: rtl/rtc_bus_burst_seq_pkg.sv
// Shared types for the RTC bus burst sequencer: FSM states, strobe levels,
// and the phase-timer load selector.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_STB,
    A_GAP,
    D_STB,
    D_GAP,
    FINISH,
    VFY
  } state_e;

  localparam logic STROBE_ACT  = 1'b0;
  localparam logic STROBE_IDLE = 1'b1;

  // Selects which duration the phase timer reloads with
  typedef enum logic {
    PH_STB,
    PH_GAP
  } phase_sel_e;

endpackage

// File: rtl/rtc_bus_burst_seq_phase_timer.sv
// Loadable down-counter timing strobe and gap phases of the RTC bus.
// Loading T-1 makes the phase last exactly T cycles; expired marks the
// final cycle of the phase.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE = 10,
  parameter int unsigned T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  phase_sel_e sel,
  output logic       expired
);

  localparam int unsigned T_MAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  assign load_val = (sel == PH_STB) ? CNT_W'(T_PHASE - 1) : CNT_W'(T_GAP - 1);
  assign expired  = (cnt == '0);

  // Reload on phase entry, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/rtc_bus_burst_seq.sv
// Burst sequencer for a multiplexed address/data parallel RTC bus.
// Transfers NUM_REGS registers per start as one read or write burst.
// Optional feature macro: RTC_READBACK_CHECK_EN (write burst followed by a
// read-back verify pass that flags mismatches on err).
module rtc_bus_burst_seq
  import rtc_bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 10,
  parameter int unsigned DATA_W   = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] REG_ADDRS = 80'h09_08_07_06_05_04_03_02_01_00,
  parameter int unsigned T_PHASE  = 10,
  parameter int unsigned T_GAP    = 4,
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_din
);

`ifdef RTC_READBACK_CHECK_EN
  localparam bit VFY_EN = 1'b1;
  logic err_q;
  assign err = err_q;
`else
  localparam bit VFY_EN = 1'b0;
  assign err = 1'b0;
`endif

  state_e           state;
  logic             write_q;
  logic             vfy_q;
  logic             tmr_load;
  phase_sel_e       tmr_sel;
  logic             tmr_exp;
  logic             last_reg;
  logic             drive_wr;
  logic [IDX_W-1:0] idx_nxt;
  logic [DATA_W-1:0] addr_cur;
  logic [DATA_W-1:0] addr_nxt;

  assign last_reg = (idx == IDX_W'(NUM_REGS - 1));
  assign idx_nxt  = last_reg ? '0 : idx + IDX_W'(1);
  assign addr_cur = REG_ADDRS[DATA_W*int'(idx) +: DATA_W];
  assign addr_nxt = REG_ADDRS[DATA_W*int'(idx_nxt) +: DATA_W];
  // The verify pass reuses the read path of a write burst
  assign drive_wr = write_q && !vfy_q;

  rtc_phase_timer #(
    .T_PHASE(T_PHASE),
    .T_GAP  (T_GAP)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .sel    (tmr_sel),
    .expired(tmr_exp)
  );

  // Reload the phase timer on every phase transition
  always_comb begin
    tmr_load = 1'b0;
    tmr_sel  = PH_STB;
    case (state)
      IDLE, FINISH: tmr_load = start;
      A_STB, D_STB: begin
        tmr_load = tmr_exp;
        tmr_sel  = PH_GAP;
      end
      A_GAP, D_GAP: tmr_load = tmr_exp;
      default: tmr_load = 1'b0;
    endcase
  end

  // Burst FSM with registered bus strobes and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_d      <= STROBE_IDLE;
      cs       <= STROBE_IDLE;
      rd       <= STROBE_IDLE;
      wr       <= STROBE_IDLE;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      idx      <= '0;
      rd_data  <= '0;
      write_q  <= 1'b0;
      vfy_q    <= 1'b0;
`ifdef RTC_READBACK_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        // FINISH is the done cycle; it accepts a new start like IDLE
        IDLE, FINISH: begin
          state <= IDLE;
          if (start) begin
            state    <= A_STB;
            write_q  <= rw;
            vfy_q    <= 1'b0;
            busy     <= 1'b1;
            a_d      <= STROBE_ACT;
            cs       <= STROBE_ACT;
            wr       <= STROBE_ACT;
            bus_dout <= addr_cur;
            bus_oe   <= 1'b1;
`ifdef RTC_READBACK_CHECK_EN
            err_q    <= 1'b0;
`endif
          end
        end
        A_STB: if (tmr_exp) begin
          state <= A_GAP;
          a_d   <= STROBE_IDLE;
          cs    <= STROBE_IDLE;
          wr    <= STROBE_IDLE;
        end
        A_GAP: if (tmr_exp) begin
          state <= D_STB;
          cs    <= STROBE_ACT;
          if (drive_wr) begin
            wr       <= STROBE_ACT;
            bus_dout <= wr_data;
            bus_oe   <= 1'b1;
          end else begin
            rd     <= STROBE_ACT;
            bus_oe <= 1'b0;
          end
        end
        D_STB: begin
          if (drive_wr)
            bus_dout <= wr_data;
          if (tmr_exp) begin
            state <= D_GAP;
            cs    <= STROBE_IDLE;
            rd    <= STROBE_IDLE;
            wr    <= STROBE_IDLE;
            if (!drive_wr) begin
              rd_data  <= bus_din;
              rd_valid <= !vfy_q;
`ifdef RTC_READBACK_CHECK_EN
              if (vfy_q && (bus_din != wr_data))
                err_q <= 1'b1;
`endif
            end
          end
        end
        D_GAP: if (tmr_exp) begin
          idx <= idx_nxt;
          if (!last_reg || (VFY_EN && drive_wr)) begin
            if (last_reg)
              vfy_q <= 1'b1;
            state    <= A_STB;
            a_d      <= STROBE_ACT;
            cs       <= STROBE_ACT;
            wr       <= STROBE_ACT;
            bus_dout <= addr_nxt;
            bus_oe   <= 1'b1;
          end else begin
            state  <= FINISH;
            done   <= 1'b1;
            busy   <= 1'b0;
            bus_oe <= 1'b0;
            vfy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
